lampfpu_sqrt_rndpack: RTL
=========================

// Module: lampfpu_sqrt_rndpack
// PURPOSE
//  Downstream post-processing stage of the square-root/inverse-square-root datapath.
//  Captures per-operation metadata at dispatch, then consumes the 16-bit fixed-point
//  result from the fractional sqrt iterator. Normalizes, rounds to nearest-even, applies
//  exponent overflow/underflow rules and packs a LAMP float. Presents it with a valid/ready handshake.
// PARAMETERS
//  F_DW     7    stored fraction bits of packed result
//  E_DW     8    exponent bits of packed result
//  BIAS     127  exponent bias
//  FX_DW    16   width of fixed-point input, 2*(1+F_DW)
// PORTS
//  clk             in   1       clock, all logic on rising edge
//  rst             in   1       synchronous reset, active-high
//  doSqrt_i        in   1       dispatch strobe, same cycle the iterator receives doSqrt_i
//  special_case_i  in   1       operand is NaN/inf/zero/negative; result is special_res_i
//  special_res_i   in   1+E+F   pre-packed special result
//  exp_res_i       in   E_DW+2  signed unbiased result exponent, before normalization
//  fract_valid_i   in   1       iterator result valid (single-cycle pulse)
//  fract_res_i     in   FX_DW   iterator result, Q1.15 unsigned, value in [0.5,2)
//  ready_i         in   1       consumer accepts res_o this cycle
//  busy_o          out  1       high in every state except IDLE
//  valid_o         out  1       res_o/flags valid
//  res_o           out  1+E+F   packed result {sign,exp,frac}
//  of_o,uf_o,nx_o  out  1 each  overflow, underflow (flush), inexact
// BEHAVIOUR
//  Reset: state IDLE; valid_o=0, res_o=0, of_o=uf_o=nx_o=0, busy_o=0. All metadata regs cleared.
//   Reset mid-operation abandons the op; a later fract_valid_i is ignored.
//  FSM IDLE -> WAIT -> NORM -> RND -> HOLD -> IDLE:
//   IDLE: doSqrt_i & special_case_i -> HOLD, res_o<=special_res_i, flags 0.
//         doSqrt_i & ~special_case_i -> WAIT, latch exp_res_i.
//   WAIT: fract_valid_i -> NORM, latch fract_res_i. Otherwise stay. No timeout.
//   NORM: fx[15]=1: m=fx[14:8], g=fx[7], s=|fx[6:0], e=exp.
//         fx[15:14]=01: m=fx[13:7], g=fx[6], s=|fx[5:0], e=exp-1.
//         fx[15:14]=00: force +0, set uf. Then -> RND.
//   RND: RNE, round up if g&(s|m[0]). m=7F with round-up wraps to 00 and gives e+1.
//        nx=g|s. Biased be=e+BIAS in E_DW+2 signed width.
//        be>=255 -> 0x7F80, of=1. be<=0 -> 0x0000, uf=1 (flush, no subnormals).
//        Otherwise {1'b0,be[7:0],m}. Sign is always 0. Registers res_o/flags -> HOLD.
//   HOLD: valid_o=1; res_o and flags stable while ~ready_i.
//         ready_i -> IDLE, valid_o=0 next cycle.
//  Latency: special case, valid_o high 1 cycle after doSqrt_i. Normal case, valid_o high
//   3 cycles after fract_valid_i (NORM, RND, HOLD).
//  doSqrt_i outside IDLE is ignored; upstream must stall on busy_o.
//  fract_valid_i outside WAIT is ignored, including the pulse the iterator emits for special cases.
//  Simultaneous doSqrt_i & fract_valid_i in IDLE: only doSqrt_i acts.
//  In HOLD, ready_i and doSqrt_i in the same cycle: doSqrt_i is dropped (busy_o was high).
// TESTING
//  1 Dispatch exp_res_i=1, fract 0x8000 -> res_o 0x4000 (2.0), flags 0, valid_o 3 cycles after fract_valid_i.
//  2 exp 0, fract 0xB505 -> 0x3FB5, nx=1.
//    exp 0, fract 0x4000 -> 0x3F00 (low-normalize path).
//  3 RNE: fract 0x8180 -> 0x3F82.
//    fract 0x8080 -> 0x3F80 (tie to even).
//    fract 0xFF80 -> 0x4000 (mantissa carry bumps exponent).
//  4 Range: exp 128, 0x8000 -> 0x7F80, of=1.
//    exp -127, 0x8000 -> 0x0000, uf=1.
//    fract 0x0000 -> 0x0000, uf=1.
//  5 Special: doSqrt_i+special_case_i, special_res_i=0x7FC0 -> valid_o next cycle, res_o 0x7FC0.
//    A following fract_valid_i is ignored.
//  6 Backpressure/reset: hold ready_i=0 for 5 cycles -> res_o stable, busy_o=1, doSqrt_i ignored.
//    Assert rst in WAIT -> IDLE; a stray fract_valid_i produces no valid_o.

Source files
------------

// File: rtl/lampfpu_sqrt_rndpack.sv
// rtl/lampfpu_sqrt_rndpack.sv - sqrt/rsqrt result normalize, round-to-nearest-even and LAMP pack stage
//
// Purpose: captures operation metadata at dispatch, waits for the fixed-point
// result of the fractional sqrt iterator, normalizes it, rounds to nearest-even,
// applies exponent overflow/underflow (flush-to-zero) rules and presents a packed
// {sign,exp,frac} float behind a valid/ready handshake.
//
// Ports:
//   clk, rst        clock (rising edge), synchronous active-high reset
//   doSqrt_i        dispatch strobe, accepted only while idle
//   special_case_i  dispatched operand is special; result is special_res_i
//   special_res_i   pre-packed special result
//   exp_res_i       signed unbiased result exponent before normalization
//   fract_valid_i   iterator result strobe, accepted only while waiting
//   fract_res_i     iterator result, Q1.15 unsigned in [0.5,2)
//   ready_i         consumer accepts res_o
//   busy_o          stage is not idle
//   valid_o         res_o and flags are valid
//   res_o           packed result
//   of_o/uf_o/nx_o  overflow, underflow (flush), inexact

module lampfpu_sqrt_rndpack #(
  parameter int F_DW  = 7,
  parameter int E_DW  = 8,
  parameter int BIAS  = 127,
  parameter int FX_DW = 2*(1+F_DW)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   doSqrt_i,
  input  logic                   special_case_i,
  input  logic [E_DW+F_DW:0]     special_res_i,
  input  logic signed [E_DW+1:0] exp_res_i,
  input  logic                   fract_valid_i,
  input  logic [FX_DW-1:0]       fract_res_i,
  input  logic                   ready_i,
  output logic                   busy_o,
  output logic                   valid_o,
  output logic [E_DW+F_DW:0]     res_o,
  output logic                   of_o,
  output logic                   uf_o,
  output logic                   nx_o
);

  localparam int EW = E_DW + 2;
  localparam int RW = 1 + E_DW + F_DW;

  localparam logic signed [EW-1:0] BIAS_S = EW'(BIAS);
  localparam logic signed [EW-1:0] BE_MAX = EW'((1 << E_DW) - 1);
  localparam logic [RW-1:0]        INF_RES = {1'b0, {E_DW{1'b1}}, {F_DW{1'b0}}};

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_WAIT = 3'd1;
  localparam logic [2:0] S_NORM = 3'd2;
  localparam logic [2:0] S_RND  = 3'd3;
  localparam logic [2:0] S_HOLD = 3'd4;

  logic [2:0]              state;
  logic signed [EW-1:0]    exp_q;
  logic [FX_DW-1:0]        fx_q;
  logic [F_DW-1:0]         m_q;
  logic                    g_q;
  logic                    s_q;
  logic signed [EW-1:0]    e_q;
  logic                    zero_q;

  // Normalization of the latched iterator result
  logic [F_DW-1:0]         m_n;
  logic                    g_n;
  logic                    s_n;
  logic signed [EW-1:0]    e_n;
  logic                    zero_n;

  always_comb begin
    m_n    = '0;
    g_n    = 1'b0;
    s_n    = 1'b0;
    e_n    = exp_q;
    zero_n = 1'b0;
    if (fx_q[FX_DW-1]) begin
      m_n = fx_q[FX_DW-2 -: F_DW];
      g_n = fx_q[FX_DW-2-F_DW];
      s_n = |fx_q[FX_DW-3-F_DW:0];
    end else if (fx_q[FX_DW-2]) begin
      m_n = fx_q[FX_DW-3 -: F_DW];
      g_n = fx_q[FX_DW-3-F_DW];
      s_n = |fx_q[FX_DW-4-F_DW:0];
      e_n = exp_q - EW'(1);
    end else begin
      // Result below 0.5 cannot come from a well-formed iteration; flush to +0
      zero_n = 1'b1;
    end
  end

  // Round to nearest-even, then range check on the biased exponent
  logic                    round_up;
  logic [F_DW:0]           m_sum;
  logic signed [EW-1:0]    e_adj;
  logic signed [EW-1:0]    be;
  logic [RW-1:0]           res_n;
  logic                    of_n;
  logic                    uf_n;
  logic                    nx_n;

  always_comb begin
    round_up = g_q & (s_q | m_q[0]);
    // Carry out of the mantissa means 1.111..1 rounded to 10.000..0
    m_sum    = {1'b0, m_q} + {{F_DW{1'b0}}, round_up};
    e_adj    = e_q + $signed({{(EW-1){1'b0}}, m_sum[F_DW]});
    be       = e_adj + BIAS_S;
    res_n    = '0;
    of_n     = 1'b0;
    uf_n     = 1'b0;
    nx_n     = g_q | s_q;
    if (zero_q) begin
      uf_n = 1'b1;
      nx_n = 1'b0;
    end else if (!be[EW-1] && (be >= BE_MAX)) begin
      res_n = INF_RES;
      of_n  = 1'b1;
    end else if (be[EW-1] || (be == '0)) begin
      uf_n  = 1'b1;
    end else begin
      res_n = {1'b0, be[E_DW-1:0], m_sum[F_DW-1:0]};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      valid_o <= 1'b0;
      res_o   <= '0;
      of_o    <= 1'b0;
      uf_o    <= 1'b0;
      nx_o    <= 1'b0;
      exp_q   <= '0;
      fx_q    <= '0;
      m_q     <= '0;
      g_q     <= 1'b0;
      s_q     <= 1'b0;
      e_q     <= '0;
      zero_q  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (doSqrt_i) begin
            if (special_case_i) begin
              res_o   <= special_res_i;
              of_o    <= 1'b0;
              uf_o    <= 1'b0;
              nx_o    <= 1'b0;
              valid_o <= 1'b1;
              state   <= S_HOLD;
            end else begin
              exp_q <= exp_res_i;
              state <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          if (fract_valid_i) begin
            fx_q  <= fract_res_i;
            state <= S_NORM;
          end
        end
        S_NORM: begin
          m_q    <= m_n;
          g_q    <= g_n;
          s_q    <= s_n;
          e_q    <= e_n;
          zero_q <= zero_n;
          state  <= S_RND;
        end
        S_RND: begin
          res_o   <= res_n;
          of_o    <= of_n;
          uf_o    <= uf_n;
          nx_o    <= nx_n;
          valid_o <= 1'b1;
          state   <= S_HOLD;
        end
        S_HOLD: begin
          if (ready_i) begin
            valid_o <= 1'b0;
            state   <= S_IDLE;
          end
        end
        default: begin
          valid_o <= 1'b0;
          state   <= S_IDLE;
        end
      endcase
    end
  end

  assign busy_o = (state != S_IDLE);

endmodule
